// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer: multi-cycle 16-bit float adder controller.
// Sequences compare, align, add/sub and normalize one step per cycle.
// Ports: clk, rst_n (async, active-low), start, in_A, in_B -> busy,
//   done (1-cycle pulse), result (held), overflow (held with result).
// Optional macro FP_ADD_SUB_EN adds op_sub (B sign flipped at latch).
module fp_add_sequencer #(
   parameter int MAX_ALIGN = 12
) (
   input  logic        clk,
   input  logic        rst_n,
`ifdef FP_ADD_SUB_EN
   input  logic        op_sub,
`endif
   input  logic        start,
   input  logic [15:0] in_A,
   input  logic [15:0] in_B,
   output logic        busy,
   output logic        done,
   output logic [15:0] result,
   output logic        overflow
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMP,
      S_ALIGN,
      S_ADD,
      S_NORM,
      S_DONE
   } state_t;

   state_t      r_state;
   state_t      w_next;

   logic [15:0] r_a;
   logic [15:0] r_b;
   logic        r_sig_l;
   logic        r_sig_s;
   logic [4:0]  r_exp;
   logic [11:0] r_man_l;
   logic [11:0] r_man_s;
   logic [4:0]  r_cnt;
   logic [15:0] r_result;
   logic        r_ovf;

   logic [15:0] w_b_in;
   logic [4:0]  w_ea;
   logic [4:0]  w_eb;
   logic [11:0] w_ma;
   logic [11:0] w_mb;
   logic        w_a_ge;
   logic [4:0]  w_diff;
   logic        w_cap;
   logic [5:0]  w_exp_inc;
   logic [4:0]  w_exp_dec;

`ifdef FP_ADD_SUB_EN
   assign w_b_in = {in_B[15] ^ op_sub, in_B[14:0]};
`else
   assign w_b_in = in_B;
`endif

   // Zero exponent flushes the operand to zero (no denormals).
   assign w_ea = r_a[14:10];
   assign w_eb = r_b[14:10];
   assign w_ma = (w_ea == 5'd0) ? 12'd0 : {2'b01, r_a[9:0]};
   assign w_mb = (w_eb == 5'd0) ? 12'd0 : {2'b01, r_b[9:0]};

   // Ties on exponent fall back to mantissa; A wins full ties.
   assign w_a_ge = (w_ea > w_eb) ||
                   ((w_ea == w_eb) && (w_ma >= w_mb));
   assign w_diff = w_a_ge ? (w_ea - w_eb) : (w_eb - w_ea);

   assign w_cap     = (r_cnt > 5'(MAX_ALIGN));
   assign w_exp_inc = {1'b0, r_exp} + 6'd1;
   assign w_exp_dec = r_exp - 5'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      done   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start) w_next = S_CMP;
         end
         S_CMP: begin
            busy   = 1'b1;
            w_next = (w_diff != 5'd0) ? S_ALIGN : S_ADD;
         end
         S_ALIGN: begin
            busy = 1'b1;
            if (w_cap || r_cnt == 5'd1) w_next = S_ADD;
         end
         S_ADD: begin
            busy   = 1'b1;
            w_next = S_NORM;
         end
         S_NORM: begin
            busy   = 1'b1;
            w_next = S_DONE;
            // Only a left shift that keeps exp above 0 stays here.
            if (r_man_l != 12'd0 && !r_man_l[11] &&
                !r_man_l[10] && w_exp_dec != 5'd0)
               w_next = S_NORM;
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= 16'd0;
         r_b      <= 16'd0;
         r_sig_l  <= 1'b0;
         r_sig_s  <= 1'b0;
         r_exp    <= 5'd0;
         r_man_l  <= 12'd0;
         r_man_s  <= 12'd0;
         r_cnt    <= 5'd0;
         r_result <= 16'd0;
         r_ovf    <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a <= in_A;
                  r_b <= w_b_in;
               end
            end
            S_CMP: begin
               r_sig_l <= w_a_ge ? r_a[15] : r_b[15];
               r_sig_s <= w_a_ge ? r_b[15] : r_a[15];
               r_exp   <= w_a_ge ? w_ea : w_eb;
               r_man_l <= w_a_ge ? w_ma : w_mb;
               r_man_s <= w_a_ge ? w_mb : w_ma;
               r_cnt   <= w_diff;
            end
            S_ALIGN: begin
               if (w_cap) begin
                  r_man_s <= 12'd0;
                  r_cnt   <= 5'd0;
               end else begin
                  r_man_s <= r_man_s >> 1;
                  r_cnt   <= r_cnt - 5'd1;
               end
            end
            S_ADD: begin
               // Larger magnitude is r_man_l, so the difference is >= 0.
               if (r_sig_l == r_sig_s) r_man_l <= r_man_l + r_man_s;
               else                    r_man_l <= r_man_l - r_man_s;
            end
            S_NORM: begin
               if (r_man_l == 12'd0) begin
                  r_result <= 16'd0;
                  r_ovf    <= 1'b0;
               end else if (r_man_l[11]) begin
                  // A carry-out shift always leaves a normalized value.
                  if (w_exp_inc >= 6'd31) begin
                     r_result <= {r_sig_l, 5'h1F, 10'd0};
                     r_ovf    <= 1'b1;
                  end else begin
                     r_result <= {r_sig_l, w_exp_inc[4:0],
                                  r_man_l[10:1]};
                     r_ovf    <= 1'b0;
                  end
               end else if (!r_man_l[10]) begin
                  r_man_l <= r_man_l << 1;
                  r_exp   <= w_exp_dec;
                  if (w_exp_dec == 5'd0) begin
                     r_result <= 16'd0;
                     r_ovf    <= 1'b0;
                  end
               end else begin
                  r_result <= {r_sig_l, r_exp, r_man_l[9:0]};
                  r_ovf    <= 1'b0;
               end
            end
            S_DONE: ;
            default: ;
         endcase
      end
   end

   assign result   = r_result;
   assign overflow = r_ovf;

endmodule
